// File: rtl/uart_rx_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_mmio_if
// Description : Pin-side serial input plus MMIO status/data bundle for the
//               UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_mmio_if;
    logic       rx_i;
    logic       rx_clear_i;
    logic [7:0] rx_data_o;
    logic       rx_ready_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    modport master (
        output rx_i,
        output rx_clear_i,
        input  rx_data_o,
        input  rx_ready_o,
        input  frame_err_o,
        input  overrun_o,
        input  busy_o
    );

    modport slave (
        input  rx_i,
        input  rx_clear_i,
        output rx_data_o,
        output rx_ready_o,
        output frame_err_o,
        output overrun_o,
        output busy_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_mmio
// Description : 8N1 UART receiver with sticky ready / frame-error / overrun
//               flags, acknowledged by a one-cycle clear pulse from the core.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_mmio_if.slave bus
);

    localparam logic [2:0] c_s_idle  = 3'd0;
    localparam logic [2:0] c_s_start = 3'd1;
    localparam logic [2:0] c_s_data  = 3'd2;
    localparam logic [2:0] c_s_stop  = 3'd3;
    localparam logic [2:0] c_s_break = 3'd4;

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_sync;
    logic             w_rxs;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_ready;
    logic             r_ferr;
    logic             r_ovr;
    logic             r_busy;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_ready_nxt;
    logic             w_ferr_nxt;
    logic             w_ovr_nxt;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.rx_i};
        end
    end

    assign w_rxs = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_s_idle;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_ready <= w_ready_nxt;
            r_ferr  <= w_ferr_nxt;
            r_ovr   <= w_ovr_nxt;
            r_busy  <= (w_state_nxt != c_s_idle);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_ready_nxt = r_ready & ~bus.rx_clear_i;
        w_ferr_nxt  = r_ferr  & ~bus.rx_clear_i;
        w_ovr_nxt   = r_ovr   & ~bus.rx_clear_i;

        case (r_state)
            c_s_idle: begin
                if (!w_rxs) begin
                    w_state_nxt = c_s_start;
                    w_cnt_nxt   = '0;
                end
            end
            c_s_start: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt = '0;
                    if (!w_rxs) begin
                        w_state_nxt = c_s_data;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = c_s_idle;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_s_data: begin
                if (r_cnt == c_bit_last) begin
                    w_shift_nxt[r_idx] = w_rxs;
                    w_cnt_nxt          = '0;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = c_s_stop;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_s_stop: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        // A publish overrides a coincident clear for ready.
                        w_data_nxt  = r_shift;
                        w_ready_nxt = 1'b1;
                        w_ferr_nxt  = 1'b0;
                        w_ovr_nxt   = w_ovr_nxt | (r_ready & ~bus.rx_clear_i);
                        w_state_nxt = c_s_idle;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = c_s_break;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_s_break: begin
                if (w_rxs) begin
                    w_state_nxt = c_s_idle;
                end
            end
            default: begin
                w_state_nxt = c_s_idle;
            end
        endcase
    end

    assign bus.rx_data_o   = r_data;
    assign bus.rx_ready_o  = r_ready;
    assign bus.frame_err_o = r_ferr;
    assign bus.overrun_o   = r_ovr;
    assign bus.busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_mmio
// Description : Scoreboard bench for uart_rx_mmio; a flag-level model queues
//               the expected status at the end of every receive attempt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_mmio;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    uart_rx_mmio_if bus();

    uart_rx_mmio #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       ready;
        logic       ferr;
        logic       ovr;
        int         tmin;
        int         tmax;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_data;
    logic       m_ready;
    logic       m_ferr;
    logic       m_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int tmin, input int tmax);
        exp_t e;
        e.data  = m_data;
        e.ready = m_ready;
        e.ferr  = m_ferr;
        e.ovr   = m_ovr;
        e.tmin  = tmin;
        e.tmax  = tmax;
        sb.push_back(e);
    endtask

    task automatic model_good(input logic [7:0] b, input logic clr_same);
        if (clr_same) m_ovr = 1'b0;
        else if (m_ready) m_ovr = 1'b1;
        m_ready = 1'b1;
        m_data  = b;
        m_ferr  = 1'b0;
    endtask

    task automatic model_clear();
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Drives a whole frame one clock per sample; cut > 0 abandons it early.
    task automatic send(input logic [7:0] b, input logic stop, input int cut);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            if (cut > 0 && i == cut) return;
            bus.rx_i = frame[i / CPB];
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_pulse();
        bus.rx_clear_i = 1'b1;
        @(negedge clk);
        bus.rx_clear_i = 1'b0;
        model_clear();
    endtask

    task automatic good_frame(input logic [7:0] b, input int gap_bits, input logic do_clr);
        model_good(b, 1'b0);
        push_exp(cyc + 154, cyc + 156);
        send(b, 1'b1, 0);
        if (gap_bits > 0 && do_clr) begin
            idle(4);
            clear_pulse();
            idle(gap_bits * CPB - 5);
        end else begin
            idle(gap_bits * CPB);
        end
    endtask

    task automatic bad_frame(input logic [7:0] b, input int hold, input logic do_clr);
        m_ferr = 1'b1;
        push_exp(0, 32'h7fff_ffff);
        send(b, 1'b0, 0);
        repeat (hold) @(negedge clk);
        idle(CPB);
        if (do_clr) clear_pulse();
        idle(CPB);
    endtask

    task automatic glitch();
        push_exp(cyc, cyc + 12);
        bus.rx_i = 1'b0;
        repeat (4) @(negedge clk);
        idle(2 * CPB);
    endtask

    // Monitor: every end of a receive attempt (busy falling) pops one record.
    logic prev_busy  = 1'b0;
    logic prev_ready = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_busy  = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_busy && !bus.busy_o) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_end_of_frame: got busy fall at cycle %0d, required none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_data",  {24'd0, bus.rx_data_o}, {24'd0, mon_e.data});
                    chk("sb_ready", {31'd0, bus.rx_ready_o}, {31'd0, mon_e.ready});
                    chk("sb_ferr",  {31'd0, bus.frame_err_o}, {31'd0, mon_e.ferr});
                    chk("sb_ovr",   {31'd0, bus.overrun_o}, {31'd0, mon_e.ovr});
                    total++;
                    if (cyc < mon_e.tmin || cyc > mon_e.tmax) begin
                        bad++;
                        $display("FAIL sb_timing: got cycle %0d required %0d..%0d", cyc, mon_e.tmin, mon_e.tmax);
                    end
                end
            end else if (!prev_ready && bus.rx_ready_o) begin
                total++;
                bad++;
                $display("FAIL spurious_ready: got rise at cycle %0d, required none", cyc);
            end
            prev_busy  = bus.busy_o;
            prev_ready = bus.rx_ready_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int t0;
        bus.rx_i       = 1'b1;
        bus.rx_clear_i = 1'b0;
        rst            = 1'b1;
        m_data = 8'h00; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);

        chk("reset_data",  {24'd0, bus.rx_data_o}, 32'h00);
        chk("reset_ready", {31'd0, bus.rx_ready_o}, 32'd0);
        chk("reset_ferr",  {31'd0, bus.frame_err_o}, 32'd0);
        chk("reset_ovr",   {31'd0, bus.overrun_o}, 32'd0);
        chk("reset_busy",  {31'd0, bus.busy_o}, 32'd0);

        good_frame(8'hA5, 2, 1'b0);
        glitch();
        bad_frame(8'h3C, 40, 1'b0);
        good_frame(8'h81, 2, 1'b1);

        good_frame(8'h11, 0, 1'b0);
        good_frame(8'h22, 2, 1'b0);
        clear_pulse();
        chk("clear_ready", {31'd0, bus.rx_ready_o}, 32'd0);
        chk("clear_ferr",  {31'd0, bus.frame_err_o}, 32'd0);
        chk("clear_ovr",   {31'd0, bus.overrun_o}, 32'd0);

        // Ready already set, then clear lands exactly on the publish edge.
        good_frame(8'h33, 1, 1'b0);
        model_good(8'h5A, 1'b1);
        push_exp(cyc + 154, cyc + 156);
        t0 = cyc;
        fork
            send(8'h5A, 1'b1, 0);
            begin
                while (cyc < t0 + 154) @(negedge clk);
                bus.rx_clear_i = 1'b1;
                @(negedge clk);
                bus.rx_clear_i = 1'b0;
            end
        join
        idle(2 * CPB);
        clear_pulse();

        // Reset in the middle of data bit 4.
        send(8'hFF, 1'b1, 5 * CPB + 8);
        rst      = 1'b1;
        bus.rx_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, bus.rx_ready_o}, 32'd0);
        chk("rst_mid_busy",  {31'd0, bus.busy_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        m_data = 8'h00;
        idle(2 * CPB);
        chk("post_rst_data",  {24'd0, bus.rx_data_o}, 32'h00);
        chk("post_rst_ready", {31'd0, bus.rx_ready_o}, 32'd0);
        good_frame(8'h0F, 2, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 1) glitch();
            else if (r < 3) bad_frame(8'($urandom), int'($urandom_range(0, 40)), 1'($urandom));
            else good_frame(8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        idle(3 * CPB);
        chk("scoreboard_drain", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Serial UART receiver that sits directly upstream of the multi-cycle RISC-V core's UART peripheral port.
- Deserializes 8N1 frames from the external Rx pin into a byte register.
- Exposes the byte with a sticky ready flag, plus framing-error and overrun status, for the core's memory-mapped load path.
- The core acknowledges each byte with a one-cycle clear pulse after reading it.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit period (50 MHz / 115200). Minimum 4.
- CNT_W, 16: width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_i  input  1  serial line from pin; idle high; asynchronous to clk
- rx_clear_i  input  1  one-cycle pulse from the core after it reads the data; clears ready, overrun and frame_err
- rx_data_o  output  8  last correctly framed byte
- rx_ready_o  output  1  sticky: an unread byte is held in rx_data_o
- frame_err_o  output  1  sticky: last frame had a stop bit of 0
- overrun_o  output  1  sticky: a new byte arrived while rx_ready_o was still 1
- busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1):
  - Synchronizer flops = 1.
  - FSM = IDLE; counter = 0; bit index = 0; shift register = 0.
  - rx_data_o=0x00, rx_ready_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
- Reset mid-frame: abandons the frame immediately. No partial byte is ever published.
- Synchronizer: rx_i passes through a 2-flop synchronizer. "rxs" denotes its output; the FSM uses only rxs.
- IDLE:
  - rxs=0 -> START, counter=0.
- START:
  - Counter increments each cycle.
  - At counter = CLKS_PER_BIT/2 - 1 (integer division), sample rxs:
    - 0 -> DATA, counter=0, bit index=0.
    - 1 -> glitch; return to IDLE with no status change.
- DATA:
  - At counter = CLKS_PER_BIT - 1, sample rxs into shift register LSB-first (bit index n -> bit n). Counter=0, bit index += 1.
  - After bit 7 is sampled -> STOP.
- STOP: at counter = CLKS_PER_BIT - 1, sample rxs:
  - 1 (good frame):
    - rx_data_o <= shift register; rx_ready_o <= 1; frame_err_o <= 0.
    - overrun_o <= 1 if rx_ready_o was already 1 and rx_clear_i is not asserted this cycle.
    - Go to IDLE.
  - 0 (framing error):
    - rx_data_o and rx_ready_o unchanged; frame_err_o <= 1.
    - Go to BREAK.
- BREAK: wait until rxs=1, then go to IDLE. A held-low line (break) does not retrigger START.
- rx_clear_i:
  - Clears rx_ready_o, overrun_o and frame_err_o on the next edge.
  - If asserted in the same cycle as a good-frame publish, the publish wins: rx_ready_o=1, overrun_o=0, new data loaded.
  - If asserted in the same cycle as a framing error: frame_err_o=1 and rx_ready_o=0.
- Latency: rx_ready_o rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after rx_i falls (±1 cycle for synchronizer phase).
- Back-to-back frames (zero idle bits) are received without loss. The receiver returns to IDLE at mid-stop-bit, which leaves half a bit period of margin.
- All outputs are registered.

Test Plan (CLKS_PER_BIT=16, 1 bit = 16 clk):
- Reset released, rx_i=1 for 100 cycles -> all outputs 0, busy_o=0, rx_data_o=0x00.
- Send 0xA5, 8N1 -> rx_ready_o rises 155±1 cycles after the start edge; rx_data_o=0xA5; frame_err_o=0; overrun_o=0.
- Glitch: rx_i low for 4 cycles, then high -> FSM returns to IDLE; rx_ready_o stays 0; busy_o drops within 12 cycles.
- Send 0x3C with stop bit 0, hold rx_i low for 40 cycles, then send 0x81 -> after the first frame: frame_err_o=1, rx_data_o unchanged. After 0x81: rx_data_o=0x81, frame_err_o=0, rx_ready_o=1.
- Send 0x11, then 0x22 back-to-back with no clear -> rx_data_o=0x22, rx_ready_o=1, overrun_o=1. Pulse rx_clear_i -> all three status flags 0.
- Assert rx_clear_i in the exact publish cycle of 0x5A -> rx_ready_o=1, rx_data_o=0x5A, overrun_o=0.
- Assert rst midway through bit 4 of 0xFF, release, then send 0x0F -> no spurious ready during or after reset; 0x0F is received correctly.
